// File: rtl/cla_slice_adder.sv
// cla_slice_adder: multi-cycle wide adder, one 16-bit CLA slice per clock
//
// Optional build macro: CLA_SLICE_SUB_EN (adds the sub port for a - b).
//
// Ports (cla_slice_adder, W = 16*NSLICE):
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a, b   in   W-bit operands, latched on the accepting edge
//   cin    in   carry into slice 0, latched on the accepting edge
//   sub    in   (CLA_SLICE_SUB_EN only) 1 = compute a - b
//   busy   out  high while slices are being computed
//   done   out  one-cycle pulse, result newly updated
//   s      out  W-bit registered sum
//   cout   out  registered carry out of the top slice
//   ovf    out  registered two's-complement overflow
//
// Also defines CLA_16bit (a, b, cin -> s, cout, GP, GG) and its 4-bit group
// block cla_4bit (a, b, cin -> s, gp, gg).

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gp,
  output logic       gg
);
  logic [3:0] p, g, c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign s = p ^ c;
  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        GP,
  output logic        GG
);
  logic [3:0] gp, gg;
  logic [4:0] c;
  for (genvar i = 0; i < 4; i++) begin : g_grp
    cla_4bit u_grp (
      .a  (a[4*i +: 4]),
      .b  (b[4*i +: 4]),
      .cin(c[i]),
      .s  (s[4*i +: 4]),
      .gp (gp[i]),
      .gg (gg[i])
    );
  end
  // Second-level lookahead: group carries come straight from cin and the
  // group generate/propagate terms, never rippling through a group.
  assign c[0] = cin;
  assign c[1] = gg[0] | (gp[0] & c[0]);
  assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
  assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
  assign GP = &gp;
  assign GG = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
  assign c[4] = GG | (GP & c[0]);
  assign cout = c[4];
endmodule

module cla_slice_adder #(
  parameter int NSLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*NSLICE-1:0] a,
  input  logic [16*NSLICE-1:0] b,
  input  logic                 cin,
`ifdef CLA_SLICE_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [16*NSLICE-1:0] s,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 16 * NSLICE;
  localparam int IW = $clog2(NSLICE);

  if (NSLICE < 2 || NSLICE > 8) begin : g_bad_nslice
    $error("cla_slice_adder: NSLICE must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  a_reg, b_reg, sum_reg, sum_nxt, b_in;
  logic [IW-1:0] idx;
  logic          carry, c_in, last;
  logic [15:0]   cla_s;
  logic          cla_cout, cla_gp_unused, cla_gg_unused;

`ifdef CLA_SLICE_SUB_EN
  // Subtraction is a + ~b + 1, so the inversion happens once at latch time.
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign last = (idx == IW'(NSLICE - 1));

  CLA_16bit u_cla (
    .a   (a_reg[{idx, 4'd0} +: 16]),
    .b   (b_reg[{idx, 4'd0} +: 16]),
    .cin (carry),
    .s   (cla_s),
    .cout(cla_cout),
    .GP  (cla_gp_unused),
    .GG  (cla_gg_unused)
  );

  // The full sum including the slice being computed this cycle, so the last
  // edge can publish s without an extra cycle.
  always_comb begin
    sum_nxt = sum_reg;
    sum_nxt[{idx, 4'd0} +: 16] = cla_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end

  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == IDLE && start) begin
      a_reg <= a;
      b_reg <= b_in;
      carry <= c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_reg <= sum_nxt;
      carry   <= cla_cout;
      idx     <= idx + 1'b1;
      if (last) begin
        s    <= sum_nxt;
        cout <= cla_cout;
        ovf  <= (a_reg[W-1] == b_reg[W-1]) && (sum_nxt[W-1] != a_reg[W-1]);
      end
    end
  end
endmodule
